// File: rtl/loopback_writer_if.sv
// rtl/loopback_writer_if.sv - line buffer and host write channel bundle for loopback_writer
interface loopback_writer_if #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 42
);
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_empty;
    logic                  fifo_deq;
    logic                  wr_almost_full;
    logic                  wr_valid;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_rsp_valid;

    modport master (
        input  fifo_data, fifo_empty, wr_almost_full, wr_rsp_valid,
        output fifo_deq, wr_valid, wr_addr, wr_data
    );

    modport slave (
        output fifo_data, fifo_empty, wr_almost_full, wr_rsp_valid,
        input  fifo_deq, wr_valid, wr_addr, wr_data
    );
endinterface

// File: rtl/loopback_writer.sv
// rtl/loopback_writer.sv - streams buffered lines to the host write channel with bounded outstanding writes
module loopback_writer #(
    parameter int DATA_WIDTH      = 512,
    parameter int ADDR_WIDTH      = 42,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [31:0]           num_lines,
    loopback_writer_if.master     wr,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           lines_written
);
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [31:0]           num_q;
    logic [31:0]           issued_q;
    logic [OW-1:0]         out_q;
    logic                  wr_valid_q;
    logic                  deq;
    logic                  rsp_ok;
    logic                  last_deq;
    logic                  start_acc;

    always_comb begin
        deq       = reset && (state == RUN) && !wr.fifo_empty && !wr.wr_almost_full
                    && (issued_q < num_q) && (out_q < MAX_OUT);
        rsp_ok    = wr.wr_rsp_valid && (out_q != '0);
        last_deq  = deq && (issued_q + 32'd1 == num_q);
        start_acc = (state == IDLE) && start;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (num_lines != 32'd0) ? RUN : DONE;
            RUN:     if (last_deq) state_nxt = DRAIN;
            DRAIN:   if (out_q == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_q        <= '0;
            idx_q         <= '0;
            wr_addr_q     <= '0;
            num_q         <= '0;
            issued_q      <= '0;
            out_q         <= '0;
            wr_valid_q    <= 1'b0;
            lines_written <= '0;
        end else begin
            wr_valid_q <= deq;
            if (start_acc) begin
                base_q        <= base_addr;
                num_q         <= num_lines;
                idx_q         <= '0;
                issued_q      <= '0;
                out_q         <= '0;
                lines_written <= '0;
            end else begin
                if (deq) begin
                    idx_q     <= idx_q + ADDR_WIDTH'(1);
                    issued_q  <= issued_q + 32'd1;
                    wr_addr_q <= base_q + idx_q;
                end
                // a pop and an ack in the same cycle cancel out
                case ({deq, rsp_ok})
                    2'b10:   out_q <= out_q + OW'(1);
                    2'b01:   out_q <= out_q - OW'(1);
                    default: out_q <= out_q;
                endcase
                if (rsp_ok) lines_written <= lines_written + 32'd1;
            end
        end
    end

    // buffer presents popped data one cycle after fifo_deq, aligned with wr_valid
    assign wr.fifo_deq = deq;
    assign wr.wr_valid = wr_valid_q;
    assign wr.wr_addr  = wr_addr_q;
    assign wr.wr_data  = wr_valid_q ? wr.fifo_data : '0;
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
endmodule

// File: tb/tb_loopback_writer.sv
// tb/tb_loopback_writer.sv - randomized self-checking bench for loopback_writer
module tb_loopback_writer;
    localparam int DW   = 64;
    localparam int AW   = 42;
    localparam int MAXO = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [31:0]   num_lines = '0;
    logic          busy;
    logic          done;
    logic [31:0]   lines_written;

    loopback_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    loopback_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .base_addr     (base_addr),
        .num_lines     (num_lines),
        .wr            (bus),
        .busy          (busy),
        .done          (done),
        .lines_written (lines_written)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // line buffer model: head data appears the cycle after a pop
    logic [DW-1:0] mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign bus.fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (bus.fifo_deq) begin
            bus.fifo_data <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end
    end

    bit af_force = 1'b0;
    bit rand_af  = 1'b0;
    always @(posedge clk) begin
        #2;
        bus.wr_almost_full = af_force || (rand_af && ($urandom_range(0, 3) == 0));
    end

    int            cyc = 0;
    int            due_q[$];
    int            ack_delay = 3;
    bit            ack_hold = 1'b0;
    logic [AW-1:0] got_addr[$];
    logic [DW-1:0] got_data[$];
    int            got_cyc[$];
    int            deq_count = 0;
    int            done_count = 0;
    int            af_deq = 0;
    int            valid_err = 0;
    logic          prev_deq = 1'b0;

    // monitor and write-response generator
    always @(negedge clk) begin
        cyc++;
        if (bus.wr_valid === 1'b1) begin
            got_addr.push_back(bus.wr_addr);
            got_data.push_back(bus.wr_data);
            got_cyc.push_back(cyc);
            due_q.push_back(cyc + ack_delay);
        end
        if (bus.wr_valid !== prev_deq) valid_err++;
        prev_deq = bus.fifo_deq;
        if (bus.fifo_deq === 1'b1) deq_count++;
        if (bus.fifo_deq === 1'b1 && bus.wr_almost_full === 1'b1) af_deq++;
        if (done === 1'b1) done_count++;
        if (!ack_hold && due_q.size() > 0 && due_q[0] <= cyc) begin
            bus.wr_rsp_valid = 1'b1;
            void'(due_q.pop_front());
        end else begin
            bus.wr_rsp_valid = 1'b0;
        end
    end

    int w0, deq0, done0, af0, rd0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic preload(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr] = {$urandom, $urandom};
            wr_ptr++;
        end
    endtask

    task automatic launch(input logic [AW-1:0] b, input int n);
        w0 = got_addr.size();
        deq0 = deq_count;
        done0 = done_count;
        af0 = af_deq;
        rd0 = rd_ptr;
        base_addr = b;
        num_lines = n;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_count == done0 && k < budget) begin
            tick(1);
            k++;
        end
        check("done_seen", 64'(done_count != done0), 64'd1);
        tick(2);
    endtask

    task automatic check_xfer(input logic [AW-1:0] b, input int n);
        int nw;
        logic [AW-1:0] exp_a;
        nw = got_addr.size() - w0;
        check("n_writes", nw, n);
        for (int i = 0; i < n && i < nw; i++) begin
            exp_a = b + AW'(i);
            check("addr", got_addr[w0 + i], exp_a);
            check("data", got_data[w0 + i], mem[rd0 + i]);
        end
        check("done_once", done_count - done0, 1);
        check("lines_written", lines_written, n);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        int n;
        logic [AW-1:0] b;

        tick(3);
        check("rst_wr_valid", bus.wr_valid, 0);
        check("rst_fifo_deq", bus.fifo_deq, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_lines", lines_written, 0);
        reset = 1'b1;
        tick(2);

        preload(4);
        ack_delay = 3;
        launch(42'h100, 4);
        wait_done(100);
        check_xfer(42'h100, 4);
        if (got_cyc.size() >= w0 + 4) check("consecutive", got_cyc[w0 + 3] - got_cyc[w0], 3);

        launch(42'h55, 0);
        check("zero_done_next", done, 1);
        wait_done(10);
        check("zero_writes", got_addr.size() - w0, 0);
        check("zero_deq", deq_count - deq0, 0);
        check("zero_done_once", done_count - done0, 1);
        check("zero_lines", lines_written, 0);

        preload(12);
        ack_hold = 1'b1;
        launch(42'h2000, 12);
        tick(30);
        check("stall_deq", deq_count - deq0, MAXO);
        check("stall_busy", busy, 1);
        ack_hold = 1'b0;
        wait_done(300);
        check_xfer(42'h2000, 12);

        preload(20);
        ack_delay = 2;
        launch(42'h4000, 20);
        for (int k = 0; k < 60 && (got_addr.size() - w0) < 5; k++) tick(1);
        af_force = 1'b1;
        tick(5);
        af_force = 1'b0;
        check("af_no_deq", af_deq - af0, 0);
        wait_done(300);
        check_xfer(42'h4000, 20);

        preload(4);
        ack_delay = 1;
        b = {AW{1'b1}} - AW'(1);
        launch(b, 4);
        wait_done(100);
        check_xfer(b, 4);

        preload(3);
        ack_delay = 15;
        launch(42'h300, 10);
        tick(8);
        check("pre_reset_deq", deq_count - deq0, 3);
        reset = 1'b0;
        #1;
        check("mid_rst_wr_valid", bus.wr_valid, 0);
        check("mid_rst_fifo_deq", bus.fifo_deq, 0);
        check("mid_rst_wr_addr", bus.wr_addr, 0);
        check("mid_rst_wr_data", bus.wr_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        tick(1);
        reset = 1'b1;
        tick(25);
        check("stale_acks_lines", lines_written, 0);
        check("stale_acks_busy", busy, 0);
        preload(5);
        ack_delay = 3;
        launch(42'h500, 5);
        wait_done(100);
        check_xfer(42'h500, 5);

        rand_af = 1'b1;
        for (int t = 0; t < 4; t++) begin
            n = $urandom_range(1, 24);
            b = AW'({$urandom, $urandom});
            ack_delay = $urandom_range(0, 6);
            preload(n);
            launch(b, n);
            wait_done(2000);
            check_xfer(b, n);
        end
        rand_af = 1'b0;

        check("valid_follows_deq", valid_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/loopback_writer.md
LOOPBACK_WRITER -- requirements
Module: loopback_writer

Interface
REQ-001 Parameter DATA_WIDTH, default 512, width of one cache line of write data.
REQ-002 Parameter ADDR_WIDTH, default 42, width of the line address.
REQ-003 Parameter MAX_OUTSTANDING, default 8, maximum writes issued but not yet acknowledged.
REQ-004 Port clk  input  1  single clock; all logic on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 Port start  input  1  one-cycle pulse that launches a transfer.
REQ-007 Port base_addr  input  ADDR_WIDTH  first line address, sampled on accepted start.
REQ-008 Port num_lines  input  32  lines to write, sampled on accepted start.
REQ-009 Port fifo_data  input  DATA_WIDTH  buffer head data, valid one cycle after fifo_deq.
REQ-010 Port fifo_empty  input  1  buffer holds no lines.
REQ-011 Port fifo_deq  output  1  pop one line from the buffer.
REQ-012 Port wr_almost_full  input  1  host write channel back-pressure.
REQ-013 Port wr_valid  output  1  write request valid this cycle.
REQ-014 Port wr_addr  output  ADDR_WIDTH  write line address.
REQ-015 Port wr_data  output  DATA_WIDTH  write payload.
REQ-016 Port wr_rsp_valid  input  1  one write acknowledged this cycle.
REQ-017 Port busy  output  1  high in any state other than IDLE.
REQ-018 Port done  output  1  one-cycle completion pulse.
REQ-019 Port lines_written  output  32  acknowledged writes in the current or last transfer.

Function
REQ-020 States: IDLE, RUN, DRAIN, DONE; the state register shall be updated only on the rising clk edge or on reset.
REQ-021 IDLE: start=1 shall latch base_addr and num_lines, clear issue index, outstanding count and lines_written; next state RUN if num_lines!=0, else DONE.
REQ-022 start shall be ignored in every state other than IDLE.
REQ-023 RUN: fifo_deq = !fifo_empty && !wr_almost_full && issued<num_lines && outstanding<MAX_OUTSTANDING, evaluated combinationally.
REQ-024 Each fifo_deq in cycle N shall produce wr_valid=1 in cycle N+1 with wr_data=fifo_data and wr_addr=base_addr+index (index 0 for the first line), registered outputs.
REQ-025 Back-to-back fifo_deq shall yield back-to-back wr_valid; throughput is one line per cycle.
REQ-026 Issue index: ADDR_WIDTH-bit increment per fifo_deq; wr_addr wraps modulo 2^ADDR_WIDTH with no error.
REQ-027 Outstanding counter, width $clog2(MAX_OUTSTANDING)+1: +1 on fifo_deq, -1 on wr_rsp_valid, unchanged when both occur in the same cycle.
REQ-028 wr_rsp_valid with outstanding==0 shall be ignored: no counter underflow, lines_written unchanged.
REQ-029 lines_written shall increment by 1 on every accepted wr_rsp_valid.
REQ-030 RUN to DRAIN in the cycle after the fifo_deq that makes issued equal num_lines.
REQ-031 DRAIN: fifo_deq=0; transition to DONE when outstanding==0.
REQ-032 DONE: done=1 for exactly one cycle, then IDLE; lines_written holds its value until the next accepted start.
REQ-033 wr_valid shall be 0 in every cycle not directly following a fifo_deq.

Reset
REQ-034 reset=0 shall force immediately, independent of clk: state IDLE, fifo_deq=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0, done=0, lines_written=0, outstanding=0, issue index=0.
REQ-035 reset asserted mid-transfer shall abandon the transfer; in-flight responses arriving after reset release shall be ignored per REQ-028.

Verification
REQ-036 base_addr=0x100, num_lines=4, buffer preloaded, no back-pressure, acks 3 cycles after each write -> wr_valid on 4 consecutive cycles, addrs 0x100..0x103, data in pop order, done once, lines_written=4.
REQ-037 num_lines=0 start -> DONE next cycle, done pulse, no fifo_deq or wr_valid.
REQ-038 MAX_OUTSTANDING=8, num_lines=12, acks withheld -> exactly 8 fifo_deq, then stall; releasing acks resumes issue; done after 12th ack.
REQ-039 wr_almost_full=1 for 5 cycles mid-transfer -> no fifo_deq in those cycles; addresses resume contiguous, none skipped or duplicated.
REQ-040 base_addr=2^ADDR_WIDTH-2, num_lines=4 -> addrs max-1, max, 0, 1.
REQ-041 reset=0 while outstanding=3 in RUN -> all outputs zero immediately; a new start after release completes normally with correct lines_written.
